sisc_fetch_unit: RTL

//  Program counter (PC), instruction register (IR) and branch resolution for the SISC CPU.

---
 rtl/sisc_pkg.sv | 37 +++
 rtl/sisc_br_cond.sv | 45 ++++
 rtl/sisc_fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, IR field positions and the fetch state encoding.
// Imported by sisc_br_cond and sisc_fetch_unit.
package sisc_pkg;

    typedef enum logic [3:0] {
        NOOP   = 4'd0,
        LOD    = 4'd1,
        STR    = 4'd2,
        SWP    = 4'd3,
        BRA    = 4'd4,
        BRR    = 4'd5,
        BNE    = 4'd6,
        BNR    = 4'd7,
        ALU_OP = 4'd8,
        HLT    = 4'd15
    } opcode_e;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned MM_MSB  = 27;
    localparam int unsigned MM_LSB  = 24;
    localparam int unsigned RD_MSB  = 23;
    localparam int unsigned RD_LSB  = 20;
    localparam int unsigned RS_MSB  = 19;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 12;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition decode: (opcode, mm, stat) -> is_branch / taken / relative.
// Purely combinational; the fetch unit qualifies the result with br_en and state.
module sisc_br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       is_branch,
    output logic       taken,
    output logic       relative
);

    logic hit;

    assign hit = |(mm & stat);

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        relative  = 1'b0;
        case (opcode)
            BRA: begin
                is_branch = 1'b1;
                taken     = hit;
            end
            BRR: begin
                is_branch = 1'b1;
                taken     = hit;
                relative  = 1'b1;
            end
            BNE: begin
                is_branch = 1'b1;
                taken     = ~hit;
            end
            BNR: begin
                is_branch = 1'b1;
                taken     = ~hit;
                relative  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC PC / IR / branch resolution with a three-state instruction fetch FSM.
// Optional taken-branch counter output br_cnt enabled by defining SISC_BR_CNT_EN.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 16,
    parameter int unsigned           INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_go,
    input  logic               pc_rst,
    input  logic               br_en,
    input  logic [3:0]         stat,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               fetch_busy,
    output logic               ir_valid,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [15:0]        imm,
    output logic [ADDR_W-1:0]  pc,
    output logic               br_taken
`ifdef SISC_BR_CNT_EN
    ,
    output logic [15:0]        br_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e       state;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               req_q;
    logic [ADDR_W-1:0]  imm_ext;
    logic               br_is, br_tk, br_rel;
    logic               idle, ack_hit, br_fire;

    assign opcode = ir_q[OPC_MSB:OPC_LSB];
    assign mm     = ir_q[MM_MSB:MM_LSB];
    assign rd     = ir_q[RD_MSB:RD_LSB];
    assign rs     = ir_q[RS_MSB:RS_LSB];
    assign rt     = ir_q[RT_MSB:RT_LSB];
    assign imm    = ir_q[IMM_MSB:IMM_LSB];

    generate
        if (ADDR_W > 16) begin : g_imm_sext
            assign imm_ext = {{(ADDR_W-16){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
        end else begin : g_imm_trunc
            assign imm_ext = ir_q[ADDR_W-1:0];
        end
    endgenerate

    sisc_br_cond u_br_cond (
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .is_branch (br_is),
        .taken     (br_tk),
        .relative  (br_rel)
    );

    assign idle    = (state == FS_IDLE);
    assign ack_hit = (state == FS_WAIT) && imem_ack;
    assign br_fire = idle && br_en && br_is && br_tk;

    // ir_valid / br_taken flag the cycle whose closing edge writes IR / PC.
    assign ir_valid   = ack_hit;
    assign br_taken   = br_fire && !pc_rst;
    assign fetch_busy = idle ? fetch_go : 1'b1;
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= FS_IDLE;
            req_q <= 1'b0;
            ir_q  <= '0;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (fetch_go) begin
                        state <= FS_REQ;
                        req_q <= 1'b1;
                    end
                end
                FS_REQ: begin
                    state <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem_ack) begin
                        state <= FS_IDLE;
                        req_q <= 1'b0;
                        ir_q  <= imem_rdata;
                    end
                end
                default: begin
                    state <= FS_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q <= RESET_PC;
        end else if (pc_rst) begin
            pc_q <= RESET_PC;
        end else if (br_fire) begin
            pc_q <= br_rel ? (pc_q + imm_ext) : imm_ext;
        end else if (ack_hit) begin
            pc_q <= pc_q + PC_ONE;
        end
    end

`ifdef SISC_BR_CNT_EN
    logic [15:0] br_cnt_q;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            br_cnt_q <= '0;
        end else if (pc_rst) begin
            br_cnt_q <= '0;
        end else if (br_fire && (br_cnt_q != '1)) begin
            br_cnt_q <= br_cnt_q + 16'd1;
        end
    end

    assign br_cnt = br_cnt_q;
`endif

endmodule
